// File: rtl/code39_bar_generator.sv
// Code 39 transmitter: serializes 6-bit character codes into narrow/wide bars and spaces.
// Optional feature macro CODE39_AUTO_STAR_EN inserts the '*' start/stop characters automatically.
module code39_bar_generator #(
    parameter int unsigned NARROW = 4,
    parameter int unsigned WIDE   = 8,
    parameter int unsigned GAP    = 4,
    parameter int unsigned QUIET  = 40,
    parameter int unsigned CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [5:0] in_code,
    input  logic       in_last,
    output logic       in_ready,
    output logic       bar,
    output logic       elem_strb,
    output logic       char_done,
    output logic       busy,
    output logic       err
);

    localparam int unsigned PAT_W = 9;
    localparam int unsigned IDX_W = 4;
    localparam logic [5:0]  STAR_CODE = 6'd43;
    localparam logic [5:0]  NUM_CODES = 6'd44;

    typedef enum logic [1:0] {S_IDLE, S_ELEM, S_GAP, S_QUIET} state_t;

    // Element pattern per code, bit8 is emitted first, 1 = wide
    function automatic logic [PAT_W-1:0] f_rom(input logic [5:0] code);
        case (code)
            6'd0:  f_rom = 9'b000110100;  6'd1:  f_rom = 9'b100100001;
            6'd2:  f_rom = 9'b001100001;  6'd3:  f_rom = 9'b101100000;
            6'd4:  f_rom = 9'b000110001;  6'd5:  f_rom = 9'b100110000;
            6'd6:  f_rom = 9'b001110000;  6'd7:  f_rom = 9'b000100101;
            6'd8:  f_rom = 9'b100100100;  6'd9:  f_rom = 9'b001100100;
            6'd10: f_rom = 9'b100001001;  6'd11: f_rom = 9'b001001001;
            6'd12: f_rom = 9'b101001000;  6'd13: f_rom = 9'b000011001;
            6'd14: f_rom = 9'b100011000;  6'd15: f_rom = 9'b001011000;
            6'd16: f_rom = 9'b000001101;  6'd17: f_rom = 9'b100001100;
            6'd18: f_rom = 9'b001001100;  6'd19: f_rom = 9'b000011100;
            6'd20: f_rom = 9'b100000011;  6'd21: f_rom = 9'b001000011;
            6'd22: f_rom = 9'b101000010;  6'd23: f_rom = 9'b000010011;
            6'd24: f_rom = 9'b100010010;  6'd25: f_rom = 9'b001010010;
            6'd26: f_rom = 9'b000000111;  6'd27: f_rom = 9'b100000110;
            6'd28: f_rom = 9'b001000110;  6'd29: f_rom = 9'b000010110;
            6'd30: f_rom = 9'b110000001;  6'd31: f_rom = 9'b011000001;
            6'd32: f_rom = 9'b111000000;  6'd33: f_rom = 9'b010010001;
            6'd34: f_rom = 9'b110010000;  6'd35: f_rom = 9'b011010000;
            6'd36: f_rom = 9'b010000101;  6'd37: f_rom = 9'b110000100;
            6'd38: f_rom = 9'b011000100;  6'd39: f_rom = 9'b010101000;
            6'd40: f_rom = 9'b010100010;  6'd41: f_rom = 9'b010001010;
            6'd42: f_rom = 9'b000101010;  6'd43: f_rom = 9'b010010100;
            default: f_rom = '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] f_width(input logic wide);
        f_width = wide ? CNT_W'(WIDE - 1) : CNT_W'(NARROW - 1);
    endfunction

    state_t             r_state, w_nxt_state;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic [IDX_W-1:0]   r_idx, w_nxt_idx, w_nidx;
    logic [PAT_W-1:0]   r_pat, w_nxt_pat, w_load_pat;
    logic               r_last, w_nxt_last;
    logic               r_ready, r_bar, r_strb, r_done, r_busy, r_err;
    logic               w_nxt_ready, w_nxt_strb, w_load;
    logic               w_code_ok, w_accept, w_invalid;
`ifdef CODE39_AUTO_STAR_EN
    logic               r_pend, w_nxt_pend;
    logic               r_tail, w_nxt_tail;
    logic               r_held_last, w_nxt_hlast;
    logic [PAT_W-1:0]   r_held_pat, w_nxt_hpat;
`endif

    assign w_code_ok = (in_code < NUM_CODES);
    assign w_accept  = in_valid & r_ready & w_code_ok;
    assign w_invalid = in_valid & r_ready & ~w_code_ok;
    assign w_nidx    = r_idx + IDX_W'(1);

    // Next-state, counter and element sequencing
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_idx   = r_idx;
        w_nxt_pat   = r_pat;
        w_nxt_last  = r_last;
        w_nxt_strb  = 1'b0;
        w_load      = 1'b0;
        w_load_pat  = '0;
`ifdef CODE39_AUTO_STAR_EN
        w_nxt_pend  = r_pend;
        w_nxt_tail  = r_tail;
        w_nxt_hlast = r_held_last;
        w_nxt_hpat  = r_held_pat;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
`ifdef CODE39_AUTO_STAR_EN
                    w_load_pat  = f_rom(STAR_CODE);
                    w_nxt_pend  = 1'b1;
                    w_nxt_hpat  = f_rom(in_code);
                    w_nxt_hlast = in_last;
                    w_nxt_last  = 1'b0;
                    w_nxt_tail  = 1'b0;
`else
                    w_load_pat = f_rom(in_code);
                    w_nxt_last = in_last;
`endif
                end
            end
            S_ELEM: begin
                if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end else if (r_idx == IDX_W'(PAT_W - 1)) begin
                    w_nxt_state = S_GAP;
                    w_nxt_cnt   = CNT_W'(GAP - 1);
                end else begin
                    w_nxt_idx  = w_nidx;
                    w_nxt_cnt  = f_width(r_pat[IDX_W'(PAT_W - 1) - w_nidx]);
                    w_nxt_strb = 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
`ifdef CODE39_AUTO_STAR_EN
                end else if (r_pend) begin
                    w_load     = 1'b1;
                    w_load_pat = r_held_pat;
                    w_nxt_last = r_held_last;
                    w_nxt_pend = 1'b0;
                end else if (r_tail) begin
                    w_nxt_state = S_QUIET;
                    w_nxt_cnt   = CNT_W'(QUIET - 1);
                    w_nxt_tail  = 1'b0;
                end else if (r_last) begin
                    w_load     = 1'b1;
                    w_load_pat = f_rom(STAR_CODE);
                    w_nxt_tail = 1'b1;
`endif
                end else if (w_accept) begin
                    w_load     = 1'b1;
                    w_load_pat = f_rom(in_code);
                    w_nxt_last = in_last;
                end else if (r_last) begin
                    w_nxt_state = S_QUIET;
                    w_nxt_cnt   = CNT_W'(QUIET - 1);
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
            S_QUIET: begin
                if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
        endcase
        if (w_load) begin
            w_nxt_state = S_ELEM;
            w_nxt_pat   = w_load_pat;
            w_nxt_idx   = '0;
            w_nxt_cnt   = f_width(w_load_pat[PAT_W-1]);
            w_nxt_strb  = 1'b1;
        end
        // Ready is offered in IDLE and in the final gap cycle of a host character
        w_nxt_ready = (w_nxt_state == S_IDLE) ||
                      ((w_nxt_state == S_GAP) && (w_nxt_cnt == '0)
`ifdef CODE39_AUTO_STAR_EN
                       && !w_nxt_pend && !w_nxt_last
`endif
                      );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_pat   <= '0;
            r_last  <= 1'b0;
            r_ready <= 1'b1;
            r_bar   <= 1'b0;
            r_strb  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
`ifdef CODE39_AUTO_STAR_EN
            r_pend      <= 1'b0;
            r_tail      <= 1'b0;
            r_held_last <= 1'b0;
            r_held_pat  <= '0;
`endif
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_idx   <= w_nxt_idx;
            r_pat   <= w_nxt_pat;
            r_last  <= w_nxt_last;
            r_ready <= w_nxt_ready;
            r_bar   <= (w_nxt_state == S_ELEM) && !w_nxt_idx[0];
            r_strb  <= w_nxt_strb;
            r_done  <= (w_nxt_state == S_GAP) && (w_nxt_cnt == '0);
            r_busy  <= (w_nxt_state != S_IDLE);
            r_err   <= w_invalid;
`ifdef CODE39_AUTO_STAR_EN
            r_pend      <= w_nxt_pend;
            r_tail      <= w_nxt_tail;
            r_held_last <= w_nxt_hlast;
            r_held_pat  <= w_nxt_hpat;
`endif
        end
    end

    assign in_ready  = r_ready;
    assign bar       = r_bar;
    assign elem_strb = r_strb;
    assign char_done = r_done;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
